// File: rtl/tmds_pkg.sv
// Shared TMDS types, control/TERC4 symbol tables and encoding helpers.
package tmds_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] tmds_disp_t;

  localparam tmds_sym_t CTRL_TOK_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_TOK_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_TOK_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_TOK_11 = 10'b1010101011;

  localparam tmds_sym_t TERC4_TBL [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimising stage: q_m[8]=1 marks the XOR chain.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n;
    logic       xn;
    logic [8:0] m;
    n    = ones8(d);
    xn   = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    m    = '0;
    m[0] = d[0];
    for (int i = 1; i < 8; i++) m[i] = xn ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
    m[8] = ~xn;
    return m;
  endfunction

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    tmds_sym_t t;
    unique case (c)
      2'b00:   t = CTRL_TOK_00;
      2'b01:   t = CTRL_TOK_01;
      2'b10:   t = CTRL_TOK_10;
      default: t = CTRL_TOK_11;
    endcase
    return t;
  endfunction

  function automatic tmds_sym_t terc4_sym(input logic [3:0] nib);
    return TERC4_TBL[nib];
  endfunction

endpackage

// File: rtl/tmds_ch_encode.sv
// One TMDS channel: stage A (q_m) and stage B (DC balance, running disparity).
// TMDS_TERC4_EN adds the island input and TERC4 symbol path.
module tmds_ch_encode
  import tmds_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       vld_a,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
`ifdef TMDS_TERC4_EN
  input  logic       island,
`endif
  output logic [9:0] q_out
);

  localparam tmds_disp_t TWO = 5'sd2;

  logic [8:0] qm_a;
  logic       de_a;
  logic [1:0] ctrl_a;
  logic       ld_b;
  logic [3:0] n1;
  tmds_disp_t diff, cnt, cnt_nxt;
  tmds_sym_t  sym_b;
`ifdef TMDS_TERC4_EN
  logic       isl_a;
  logic [3:0] nib_a;
`endif

  // Disparity only advances for real beats leaving stage A.
  assign ld_b = adv && vld_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_a   <= '0;
      de_a   <= 1'b0;
      ctrl_a <= '0;
`ifdef TMDS_TERC4_EN
      isl_a  <= 1'b0;
      nib_a  <= '0;
`endif
    end else if (adv) begin
      qm_a   <= tmds_qm(data);
      de_a   <= de;
      ctrl_a <= ctrl;
`ifdef TMDS_TERC4_EN
      isl_a  <= island;
      nib_a  <= data[3:0];
`endif
    end
  end

  always_comb begin
    n1      = ones8(qm_a[7:0]);
    diff    = tmds_disp_t'({n1, 1'b0}) - tmds_disp_t'(5'd8);  // N1-N0
    sym_b   = '0;
    cnt_nxt = cnt;
    if (de_a) begin
      if (cnt == '0 || n1 == 4'd4) begin
        sym_b   = {~qm_a[8], qm_a[8], qm_a[8] ? qm_a[7:0] : ~qm_a[7:0]};
        cnt_nxt = qm_a[8] ? cnt + diff : cnt - diff;
      end else if ((!cnt[4] && n1 > 4'd4) || (cnt[4] && n1 < 4'd4)) begin
        sym_b   = {1'b1, qm_a[8], ~qm_a[7:0]};
        cnt_nxt = cnt + (qm_a[8] ? TWO : '0) - diff;
      end else begin
        sym_b   = {1'b0, qm_a[8], qm_a[7:0]};
        cnt_nxt = cnt - (qm_a[8] ? '0 : TWO) + diff;
      end
    end
`ifdef TMDS_TERC4_EN
    else if (isl_a) begin
      sym_b = terc4_sym(nib_a);
    end
`endif
    else begin
      sym_b   = ctrl_token(ctrl_a);
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (ld_b) cnt <= cnt_nxt;
  end

  if (REG_OUT != 0) begin : g_reg
    tmds_sym_t q_r;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       q_r <= '0;
      else if (ld_b) q_r <= sym_b;
    end
    assign q_out = q_r;
  end else begin : g_comb
    assign q_out = vld_a ? sym_b : '0;
  end

endmodule

// File: rtl/tmds_encoder_pipe.sv
// NUM_CH-channel TMDS encoder with shared valid/ready flow control.
// TMDS_TERC4_EN adds the per-channel island input (TERC4 data islands).
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int REG_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_CH-1:0]     de,
  input  logic [8*NUM_CH-1:0]   data,
  input  logic [2*NUM_CH-1:0]   ctrl,
`ifdef TMDS_TERC4_EN
  input  logic [NUM_CH-1:0]     island,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*NUM_CH-1:0]  q_out
);

  localparam int STAGES = (REG_OUT != 0) ? 1 : 0;

  logic [STAGES:0] vld_pipe;
  logic            advance;

  assign out_valid = vld_pipe[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  if (STAGES == 0) begin : g_v0
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          vld_pipe <= '0;
      else if (advance) vld_pipe <= in_valid;
    end
  end else begin : g_v1
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          vld_pipe <= '0;
      else if (advance) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmds_ch_encode #(.REG_OUT(REG_OUT)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .adv    (advance),
      .vld_a  (vld_pipe[0]),
      .de     (de[c]),
      .data   (data[8*c +: 8]),
      .ctrl   (ctrl[2*c +: 2]),
`ifdef TMDS_TERC4_EN
      .island (island[c]),
`endif
      .q_out  (q_out[10*c +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Self-checking bench: directed vector table, stall/reset sequences, random stream vs model.
module tb_tmds_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  de;
  logic [23:0] data;
  logic [5:0]  ctrl;
  logic        out_valid, out_ready;
  logic [29:0] q_out;
`ifdef TMDS_TERC4_EN
  logic [2:0]  island;
`endif

  always #5 clk = ~clk;

  tmds_encoder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .de        (de),
    .data      (data),
    .ctrl      (ctrl),
`ifdef TMDS_TERC4_EN
    .island    (island),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int cnt_of(input int ch);
    int v;
    case (ch)
      0:       v = dut.g_ch[0].u_ch.cnt;
      1:       v = dut.g_ch[1].u_ch.cnt;
      default: v = dut.g_ch[2].u_ch.cnt;
    endcase
    return v;
  endfunction

  // Reference encoder written straight from the TMDS algorithm using integers.
  function automatic logic [9:0] ref_enc(input logic de_i, input logic [7:0] d,
                                         input logic [1:0] c, input int cin, output int cout);
    int n, n1;
    logic xn;
    logic [8:0] m;
    logic [9:0] q;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    xn = (n > 4) || (n == 4 && d[0] == 1'b0);
    m = '0;
    m[0] = d[0];
    for (int i = 1; i < 8; i++) m[i] = xn ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
    m[8] = ~xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(m[i]);
    q = '0;
    cout = cin;
    if (!de_i) begin
      case (c)
        2'd0:    q = 10'b1101010100;
        2'd1:    q = 10'b0010101011;
        2'd2:    q = 10'b0101010100;
        default: q = 10'b1010101011;
      endcase
      cout = 0;
    end else if (cin == 0 || n1 == 4) begin
      q    = m[8] ? {2'b01, m[7:0]} : {2'b10, ~m[7:0]};
      cout = m[8] ? cin + (2*n1 - 8) : cin + (8 - 2*n1);
    end else if ((cin > 0 && n1 > 4) || (cin < 0 && n1 < 4)) begin
      q    = {1'b1, m[8], ~m[7:0]};
      cout = cin + 2*int'(m[8]) + (8 - 2*n1);
    end else begin
      q    = {1'b0, m[8], m[7:0]};
      cout = cin + (2*n1 - 8) - 2*int'(!m[8]);
    end
    return q;
  endfunction

  function automatic int ones10(input logic [9:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(s[i]);
    return n;
  endfunction

  typedef struct {
    logic [29:0] q;
    logic [2:0]  de;
    int          c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  int   mcnt[3];
  int   bal[3];

  typedef struct {
    logic       do_rst;
    logic       de_b;
    logic       isl_b;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] q;
    int         cn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic i, input logic [7:0] d,
                     input logic [1:0] c, input logic [9:0] q, input int cn);
    vec_t v;
    v.do_rst = r; v.de_b = e; v.isl_b = i; v.d = d; v.c = c; v.q = q; v.cn = cn;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin mcnt[c] = 0; bal[c] = 0; end
  endtask

  // One cycle of streaming: drive, then score what the coming edge will transfer.
  task automatic step(input logic iv, input logic ordy, input logic [2:0] de_i,
                      input logic [23:0] d, input logic [5:0] c);
    exp_t e;
    int   nc;
    int   ec;
    logic [9:0] qs;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; de = de_i; data = d; ctrl = c;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("out_without_beat", 32'(out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("stream_sym", 32'(q_out), 32'(e.q));
        for (int ch = 0; ch < 3; ch++) begin
          ec = (ch == 0) ? e.c0 : (ch == 1) ? e.c1 : e.c2;
          if (e.de[ch]) bal[ch] += 2*ones10(q_out[10*ch +: 10]) - 10;
          else          bal[ch] = 0;
          check("balance", 32'(bal[ch]), 32'(ec));
          check("cnt_bound", 32'(bal[ch] <= 8 && bal[ch] >= -8), 32'(1));
        end
      end
    end
    if (in_valid && in_ready) begin
      e.q = '0;
      e.de = de;
      for (int ch = 0; ch < 3; ch++) begin
        qs = ref_enc(de[ch], data[8*ch +: 8], ctrl[2*ch +: 2], mcnt[ch], nc);
        mcnt[ch] = nc;
        e.q[10*ch +: 10] = qs;
      end
      e.c0 = mcnt[0]; e.c1 = mcnt[1]; e.c2 = mcnt[2];
      sb.push_back(e);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.do_rst) do_reset();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    de = {3{v.de_b}}; data = {3{v.d}}; ctrl = {3{v.c}};
`ifdef TMDS_TERC4_EN
    island = {3{v.isl_b}};
`endif
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 6 && !out_valid; k++) @(negedge clk);
    check("vec_valid", 32'(out_valid), 32'(1));
    check("vec_q", 32'(q_out), 32'({3{v.q}}));
    check("vec_cnt", 32'(cnt_of(0)), 32'(v.cn));
  endtask

  initial begin
    logic [29:0] held;
    logic [2:0]  de_r;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    de = '0; data = '0; ctrl = '0;
`ifdef TMDS_TERC4_EN
    island = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_q_out", 32'(q_out), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_cnt", 32'(cnt_of(1)), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    //   rst   de    isl   data   ctrl   expected q        cnt
    add(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 10'b0100000000, -8);
    add(1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 10'b1111111111,  2);
    add(1'b1, 1'b1, 1'b0, 8'hFF, 2'd0, 10'b1000000000, -8);
    add(1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 10'b1101010100,  0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 10'b0010101011,  0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 10'b0101010100,  0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 10'b1010101011,  0);
    add(1'b0, 1'b1, 1'b0, 8'h55, 2'd0, 10'b0100110011,  0);
    add(1'b0, 1'b1, 1'b0, 8'h01, 2'd0, 10'b0111111111,  8);
    add(1'b0, 1'b1, 1'b0, 8'h01, 2'd0, 10'b1100000000,  2);
    add(1'b0, 1'b1, 1'b0, 8'h10, 2'd0, 10'b0111110000,  2);
    add(1'b0, 1'b1, 1'b0, 8'h80, 2'd0, 10'b0110000000, -4);
    add(1'b0, 1'b1, 1'b0, 8'h80, 2'd0, 10'b1101111111,  4);
    add(1'b0, 1'b1, 1'b0, 8'hF8, 2'd0, 10'b0000000010, -4);
`ifdef TMDS_TERC4_EN
    add(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 10'b0100000000, -8);
    add(1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 10'b1010011100, -8);
    add(1'b0, 1'b0, 1'b1, 8'h0F, 2'd0, 10'b1011000011, -8);
    add(1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 10'b1111111111,  2);
`endif
    foreach (tbl[i]) apply_vec(tbl[i]);
`ifdef TMDS_TERC4_EN
    island = '0;
`endif

    // Back-pressure mid-stream on a run of 0x00 beats.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b111, 24'h0, 6'h0);
    held = '0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 3'b111, 24'h0, 6'h0);
      if (k == 0) held = q_out;
      else        check("stall_hold", 32'(q_out), 32'(held));
      check("stall_ready", 32'(in_ready), 32'(0));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b111, 24'h0, 6'h0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 1'b1, 3'b111, 24'h0, 6'h0);
    check("stall_drain", 32'(sb.size()), 32'(0));
    check("stall_cnt", 32'(cnt_of(0)), 32'(mcnt[0]));

    // Asynchronous reset with beats in flight, then a fresh beat sees cnt=0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'b111, 24'h010101, 6'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_q", 32'(q_out), 32'(0));
    check("midrst_cnt", 32'(cnt_of(2)), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin mcnt[c] = 0; bal[c] = 0; end
    in_valid = 1'b1; out_ready = 1'b1; de = 3'b111; data = 24'h0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 6 && !out_valid; k++) @(negedge clk);
    check("postrst_q", 32'(q_out), 32'({3{10'b0100000000}}));

    // Random traffic with independent per-channel de against the model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < 3; c++) de_r[c] = ($urandom_range(0, 9) < 8);
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75, de_r,
           24'($urandom), 6'($urandom));
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 1'b1, 3'b000, 24'h0, 6'h0);
    check("rand_drain", 32'(sb.size()), 32'(0));
    for (int c = 0; c < 3; c++) check("rand_cnt", 32'(cnt_of(c)), 32'(mcnt[c]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_pipe.md
TMDS_ENCODER_PIPE -- requirements
Module: tmds_encoder_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent TMDS channels.
REQ-002 SHALL have parameter REG_OUT, default 1: 1 registers q_out (latency 2); 0 drives q_out from stage B combinationally (latency 1).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: input beat present.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-007 SHALL have port de, input, NUM_CH: per-channel data enable (1 = video data, 0 = control).
REQ-008 SHALL have port data, input, 8*NUM_CH: channel c uses data[8c+7:8c].
REQ-009 SHALL have port ctrl, input, 2*NUM_CH: channel c uses ctrl[2c+1:2c].
REQ-010 SHALL have port out_valid, output, 1: q_out holds a valid symbol set.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts when out_valid && out_ready.
REQ-012 SHALL have port q_out, output, 10*NUM_CH: channel c uses q_out[10c+9:10c].

Function
REQ-013 Stage A SHALL compute q_m[8:0] per channel: XNOR chain with q_m[8]=0 if ones(data)>4 or (ones==4 and data[0]==0); otherwise XOR chain with q_m[8]=1; q_m[0]=data[0].
REQ-014 Stage B SHALL hold a signed 5-bit running disparity cnt per channel. N1 = ones(q_m[7:0]) and N0 = 8-N1.
REQ-015 If de=1 and (cnt==0 or N1==N0): q_out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt+=q_m[8]?(N1-N0):(N0-N1).
REQ-016 Else if de=1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): q_out={1, q_m[8], ~q_m[7:0]}; cnt+=2*q_m[8]+(N0-N1).
REQ-017 Else if de=1: q_out={0, q_m[8], q_m[7:0]}; cnt+=(N1-N0)-2*(~q_m[8]).
REQ-018 If de=0: q_out SHALL be the control token for ctrl: 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011 (bit9..bit0); cnt SHALL be cleared to 0.
REQ-019 Pipeline advance SHALL be advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-020 When advance=0, all stage registers and cnt SHALL hold.
REQ-021 cnt SHALL update only when a valid beat moves from stage A into stage B; bubbles SHALL NOT change cnt.
REQ-022 Channels SHALL share valid/ready but SHALL keep fully independent de, cnt and encoding.
REQ-023 Throughput SHALL be one beat per clock while out_ready=1.

Reset
REQ-024 On rst=1, all valid bits, cnt and the q_m registers SHALL clear to 0.
REQ-025 On rst=1, q_out SHALL be 0 and out_valid SHALL be 0.
REQ-026 A reset asserted mid-stream SHALL discard in-flight beats; the first beat after release SHALL encode with cnt=0.

Configuration
REQ-027 With TMDS_TERC4_EN defined, the block SHALL add input island[NUM_CH-1:0].
REQ-028 With TMDS_TERC4_EN defined, island=1 and de=0 SHALL output the TERC4 code of data[3:0] for that channel, with cnt held.
REQ-029 With TMDS_TERC4_EN defined, island=1 and de=1 SHALL be treated as de=1.
REQ-030 Without TMDS_TERC4_EN, the island port SHALL be absent and the TERC4 logic SHALL be removed.

Structure
REQ-031 Package tmds_pkg SHALL hold the control-token constants, the TERC4 16-entry table, and typedefs tmds_sym_t (10 bits) and tmds_disp_t (signed 5 bits).
REQ-032 Sub-module tmds_ch_encode SHALL contain the stage A/B datapath for one channel, including cnt; tmds_encoder_pipe SHALL instantiate NUM_CH copies and own the valid/ready control.

Verification
REQ-033 Reset, then data=0x00, de=1, two beats -> q_out 0100000000 (cnt -8), then 1111111111 (cnt 2).
REQ-034 Reset, then data=0xFF, de=1 -> q_out 1000000000, cnt -8.
REQ-035 de=0 with ctrl=00,01,10,11 -> the four tokens of REQ-018 in order; cnt reads 0 afterwards.
REQ-036 Stream of 0x00 beats with out_ready=0 for 3 cycles mid-stream -> q_out held stable and in_ready=0 for those cycles; sequence resumes with no lost or duplicated symbol and cnt matches the reference model.
REQ-037 Random data, de and out_ready for 10k beats on 3 channels -> matches the golden model; |cnt|<=8; every data symbol's ones-count balance tracks cnt.
REQ-038 With TMDS_TERC4_EN defined, island=1, de=0, data[3:0]=0x0 and then 0xF -> q_out 1010011100, then 1011000011; cnt unchanged.
